// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared instruction-memory constants and IFU state encodings
package ifu_pkg;

  // Instruction-memory interface constants shared with the datapath's im instance
  localparam logic [31:0] IM_START_ADDRESS = 32'h0000_3000;
  localparam int          IM_WORDS         = 1024;
  localparam logic        IM_ENABLED       = 1'b1;
  localparam logic        IM_DISABLED      = 1'b0;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

endpackage

// File: rtl/ifu_range_check.sv
// rtl/ifu_range_check.sv - combinational legality check of a fetch address
module ifu_range_check #(
  parameter logic [31:0] START_ADDRESS = ifu_pkg::IM_START_ADDRESS,
  parameter int          IM_WORDS      = ifu_pkg::IM_WORDS
) (
  input  logic [31:0] pc,
  output logic        misaligned,
  output logic        out_of_range
);

  // One extra bit so a window ending exactly at 2^32 cannot wrap to zero
  localparam logic [32:0] PC_LIMIT = {1'b0, START_ADDRESS} + 33'(4 * IM_WORDS);

  assign misaligned   = (pc[1:0] != 2'b00);
  assign out_of_range = (pc < START_ADDRESS) || ({1'b0, pc} >= PC_LIMIT);

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC, fetch FSM and IF/ID pipeline register
module ifu #(
  parameter logic [31:0] START_ADDRESS = ifu_pkg::IM_START_ADDRESS,
  parameter int          IM_WORDS      = ifu_pkg::IM_WORDS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] im_addr,
  output logic        im_enable,
  input  logic [31:0] im_result,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid,
  output logic        fetch_fault
);

  import ifu_pkg::*;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        misaligned;
  logic        out_of_range;
  logic        pc_bad;

  ifu_range_check #(
    .START_ADDRESS (START_ADDRESS),
    .IM_WORDS      (IM_WORDS)
  ) u_range_check (
    .pc           (pc),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  assign pc_bad = misaligned | out_of_range;

  // Redirect beats stall; pc+4 wraps freely and is caught by the range check
  always_comb begin
    pc_next = pc + 32'd4;
    if (redirect_valid) begin
      pc_next = redirect_target;
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_BOOT;
      pc         <= START_ADDRESS;
      ifid_instr <= 32'd0;
      ifid_pc    <= 32'd0;
      ifid_valid <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (pc_bad) begin
            state      <= ST_FAULT;
            ifid_valid <= 1'b0;
          end else begin
            pc <= pc_next;
            if (redirect_valid || flush) begin
              ifid_valid <= 1'b0;
            end else if (!stall) begin
              ifid_instr <= im_result;
              ifid_pc    <= pc;
              ifid_valid <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          ifid_valid <= 1'b0;
        end
        default: begin
          state      <= ST_FAULT;
          ifid_valid <= 1'b0;
        end
      endcase
    end
  end

  assign im_addr     = pc;
  assign im_enable   = (state == ST_RUN) ? IM_ENABLED : IM_DISABLED;
  assign fetch_fault = (state == ST_FAULT);

endmodule
